// File: rtl/fft_framer_pkg.sv
// -----------------------------------------------------------------------------
// fft_framer_pkg
// Shared types for the FFT stream framer: the framing FSM state encoding and
// the two-bit frame status codes driven on source_error.
// -----------------------------------------------------------------------------
package fft_framer_pkg;

    // Framing FSM: IDLE waits for data, RUN forwards samples, PAD zero-fills
    // the remainder of an aborted frame.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PAD  = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_ABORT = 2'b01;

endpackage

// File: rtl/fft_stream_framer_if.sv
// -----------------------------------------------------------------------------
// fft_stream_framer_if
// Bundles the upstream sample handshake and the downstream FFT-core source
// stream of the framer.
//   master : environment side (drives in_data/in_valid and source_ready)
//   slave  : framer side (drives in_ready and every source_* beat signal)
// -----------------------------------------------------------------------------
interface fft_stream_framer_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              source_ready;
    logic              source_valid;
    logic              source_sop;
    logic              source_eop;
    logic [1:0]        source_error;
    logic [DATA_W-1:0] source_real;
    logic [DATA_W-1:0] source_imag;

    modport master (
        output in_data, in_valid, source_ready,
        input  in_ready, source_valid, source_sop, source_eop,
               source_error, source_real, source_imag
    );

    modport slave (
        input  in_data, in_valid, source_ready,
        output in_ready, source_valid, source_sop, source_eop,
               source_error, source_real, source_imag
    );
endinterface

// File: rtl/fft_framer_fifo.sv
// -----------------------------------------------------------------------------
// fft_framer_fifo
// Synchronous first-word-fall-through buffer between the upstream sample
// source and the framing FSM.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   i_push/i_data  write request and data (ignored when full)
//   i_pop          read request (ignored when empty)
//   o_data         head-of-queue sample, valid whenever o_empty is low
//   o_full/o_empty occupancy flags
//   o_count        current occupancy (0..FIFO_DEPTH)
// -----------------------------------------------------------------------------
module fft_framer_fifo #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_push,
    input  logic [DATA_W-1:0]             i_data,
    input  logic                          i_pop,
    output logic [DATA_W-1:0]             o_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);
    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   PTR_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    // One extra pointer bit distinguishes full from empty when the
    // address bits coincide.
    logic [PTR_W:0]    r_wr_ptr;
    logic [PTR_W:0]    r_rd_ptr;
    logic              w_push;
    logic              w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_full  = (o_count == DEPTH_C);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_data  = r_mem[r_rd_ptr[PTR_W-1:0]];

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define
    // which entries are valid, and leaving the array reset-free lets it map
    // onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
    end

endmodule

// File: rtl/fft_stream_framer.sv
// -----------------------------------------------------------------------------
// fft_stream_framer
// Chops a continuous audio sample stream into fixed N = 2**LOG2_PTS point
// frames for a streaming FFT core, marking first/last beats, latching the
// transform direction per frame and zero-padding frames aborted by enable.
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   enable        permits frame start; low mid-frame aborts into padding
//   inverse_req   requested direction, sampled at each frame start
//   bus (slave)   upstream in_* handshake and downstream source_* stream
//   inverse       direction latched for the current frame
//   fft_pts       constant frame length N
//   err_count     aborted-frame counter (only with FFT_FRAMER_ERRCNT_EN)
// Optional feature macro: FFT_FRAMER_ERRCNT_EN
// -----------------------------------------------------------------------------
module fft_stream_framer
    import fft_framer_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int LOG2_PTS   = 10,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  inverse_req,
    fft_stream_framer_if.slave    bus,
    output logic                  inverse,
    output logic [LOG2_PTS:0]     fft_pts
`ifdef FFT_FRAMER_ERRCNT_EN
    ,
    output logic [15:0]           err_count
`endif
);
    localparam int                  CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [LOG2_PTS-1:0] IDX_ONE  = LOG2_PTS'(1);
    localparam logic [LOG2_PTS-1:0] LAST_IDX = '1;

    state_t              r_state;
    state_t              w_state_next;
    logic [LOG2_PTS-1:0] r_index;
    logic [LOG2_PTS-1:0] w_index_next;
    logic                r_inverse;
    logic                w_inverse_next;

    logic                w_fifo_push;
    logic                w_fifo_pop;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [CNT_W-1:0]    w_fifo_count;
    logic [DATA_W-1:0]   w_fifo_data;
    logic                w_restart_ok;

    logic                w_src_valid;
    logic                w_src_sop;
    logic                w_src_eop;
    logic [1:0]          w_src_error;
    logic [DATA_W-1:0]   w_src_real;

    fft_framer_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_fifo_push),
        .i_data  (bus.in_data),
        .i_pop   (w_fifo_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign bus.in_ready = !w_fifo_full;
    assign w_fifo_push  = bus.in_valid && !w_fifo_full;

    // After the eop pop the buffer still holds a sample if more than one is
    // queued now, or one is arriving this very cycle; either allows an
    // immediate back-to-back restart.
    assign w_restart_ok = (w_fifo_count > CNT_ONE) || w_fifo_push;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_index   <= '0;
            r_inverse <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_index   <= w_index_next;
            r_inverse <= w_inverse_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block is given a default first, so no
        // path through the case statement can leave a latch behind.
        w_state_next   = r_state;
        w_index_next   = r_index;
        w_inverse_next = r_inverse;
        w_fifo_pop     = 1'b0;
        w_src_valid    = 1'b0;
        w_src_sop      = 1'b0;
        w_src_eop      = 1'b0;
        w_src_error    = ERR_NONE;
        w_src_real     = '0;

        case (r_state)
            IDLE: begin
                if (enable && !w_fifo_empty) begin
                    w_state_next   = RUN;
                    w_index_next   = '0;
                    w_inverse_next = inverse_req;
                end
            end

            RUN: begin
                w_src_valid = !w_fifo_empty;
                w_src_sop   = w_src_valid && (r_index == '0);
                w_src_eop   = w_src_valid && (r_index == LAST_IDX);
                w_src_real  = w_src_valid ? w_fifo_data : '0;
                if (w_src_valid && bus.source_ready) begin
                    w_fifo_pop = 1'b1;
                    if (r_index == LAST_IDX) begin
                        w_index_next = '0;
                        if (enable && w_restart_ok) begin
                            w_inverse_next = inverse_req;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end else begin
                        w_index_next = r_index + IDX_ONE;
                        if (!enable) w_state_next = PAD;
                    end
                end else if (!enable) begin
                    // Nothing sent yet means nothing to pad: drop the frame.
                    w_state_next = (r_index == '0) ? IDLE : PAD;
                end
            end

            PAD: begin
                w_src_valid = 1'b1;
                w_src_eop   = (r_index == LAST_IDX);
                w_src_error = w_src_eop ? ERR_ABORT : ERR_NONE;
                if (bus.source_ready) begin
                    if (r_index == LAST_IDX) begin
                        w_index_next = '0;
                        w_state_next = IDLE;
                    end else begin
                        w_index_next = r_index + IDX_ONE;
                    end
                end
            end

            default: begin
                w_state_next = IDLE;
                w_index_next = '0;
            end
        endcase
    end

    assign bus.source_valid = w_src_valid;
    assign bus.source_sop   = w_src_sop;
    assign bus.source_eop   = w_src_eop;
    assign bus.source_error = w_src_error;
    assign bus.source_real  = w_src_real;
    assign bus.source_imag  = '0;
    assign inverse          = r_inverse;
    assign fft_pts          = {1'b1, {LOG2_PTS{1'b0}}};

`ifdef FFT_FRAMER_ERRCNT_EN
    logic [15:0] r_err_count;
    logic        w_abort_done;

    assign w_abort_done = (r_state == PAD) && bus.source_ready && (r_index == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (w_abort_done && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'd1;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_fft_stream_framer.sv
// -----------------------------------------------------------------------------
// tb_fft_stream_framer
// Self-checking bench for fft_stream_framer with N = 8 and a 4-deep buffer.
// A negedge monitor records every completed source beat; each scenario task
// compares the recorded beats against frames built from the sample list.
// -----------------------------------------------------------------------------
module tb_fft_stream_framer;
    localparam int DATA_W     = 16;
    localparam int LOG2_PTS   = 3;
    localparam int FIFO_DEPTH = 4;
    localparam int N          = 1 << LOG2_PTS;

    logic                clk = 1'b0;
    logic                reset;
    logic                enable;
    logic                inverse_req;
    logic                inverse;
    logic [LOG2_PTS:0]   fft_pts;
`ifdef FFT_FRAMER_ERRCNT_EN
    logic [15:0]         err_count;
`endif

    fft_stream_framer_if #(.DATA_W(DATA_W)) bus();

    fft_stream_framer #(
        .DATA_W     (DATA_W),
        .LOG2_PTS   (LOG2_PTS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .inverse_req (inverse_req),
        .bus         (bus),
        .inverse     (inverse),
        .fft_pts     (fft_pts)
`ifdef FFT_FRAMER_ERRCNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        logic        sop;
        logic        eop;
        logic [1:0]  err;
        logic        inv;
        int          cyc;
    } beat_t;

    beat_t       beats[$];
    logic [15:0] tx_q[$];
    logic [15:0] exp_q[$];
    int          n_checks  = 0;
    int          n_pass    = 0;
    int          n_acc     = 0;
    int          cyc       = 0;
    int          stab_viol = 0;
    logic        chk_stable = 1'b0;
    logic        prev_stall = 1'b0;
    beat_t       mon_b;
    beat_t       prev_b;

    // Reference: beat at position pos of a frame carrying sample re.
    function automatic logic [36:0] exp_beat(input logic [15:0] re, input int pos,
                                             input logic aborted, input logic inv);
        logic [1:0] err;
        err = (aborted && pos == N - 1) ? 2'b01 : 2'b00;
        return {re, 16'h0000, pos == 0, pos == N - 1, err, inv};
    endfunction

    function automatic logic [36:0] got_beat(input beat_t b);
        return {b.re, b.im, b.sop, b.eop, b.err, b.inv};
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        mon_b.re  = bus.source_real;
        mon_b.im  = bus.source_imag;
        mon_b.sop = bus.source_sop;
        mon_b.eop = bus.source_eop;
        mon_b.err = bus.source_error;
        mon_b.inv = inverse;
        mon_b.cyc = cyc;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (chk_stable && prev_stall &&
                (!bus.source_valid || got_beat(mon_b) !== got_beat(prev_b)))
                stab_viol++;
            if (bus.source_valid && bus.source_ready) beats.push_back(mon_b);
            if (bus.in_valid && bus.in_ready) n_acc++;
            prev_stall = bus.source_valid && !bus.source_ready;
            prev_b     = mon_b;
        end
    end

    // One clock of stimulus; entered and left at posedge + 1.
    // ready_mode: 0 = ready high, 1 = toggle, 2 = ready low, 3 = random.
    task automatic step(input int ready_mode, input logic tog_inv);
        logic hs;
        if (tx_q.size() > 0) begin
            bus.in_valid = 1'b1;
            bus.in_data  = tx_q[0];
        end else begin
            bus.in_valid = 1'b0;
            bus.in_data  = '0;
        end
        case (ready_mode)
            0:       bus.source_ready = 1'b1;
            1:       bus.source_ready = ~bus.source_ready;
            2:       bus.source_ready = 1'b0;
            default: bus.source_ready = 1'($urandom_range(0, 1));
        endcase
        if (tog_inv) inverse_req = 1'($urandom_range(0, 1));
        @(negedge clk);
        hs = bus.in_valid && bus.in_ready;
        @(posedge clk);
        #1;
        if (hs) void'(tx_q.pop_front());
    endtask

    task automatic run_until(input int target, input int budget, input int mode,
                             input logic tog_inv, input string name);
        int c = 0;
        while (beats.size() < target && c < budget) begin
            step(mode, tog_inv);
            c++;
        end
        n_checks++;
        if (beats.size() < target)
            $display("FAIL %s timeout: beats seen %0d, required %0d", name, beats.size(), target);
        else
            n_pass++;
    endtask

    task automatic queue_samples(input int count, input logic seq);
        exp_q.delete();
        for (int i = 0; i < count; i++) begin
            logic [15:0] s;
            s = seq ? 16'(i + 1) : 16'($urandom);
            tx_q.push_back(s);
            exp_q.push_back(s);
        end
    endtask

    task automatic compare_frames(input int base, input int count, input logic inv,
                                  input string name);
        for (int i = 0; i < count; i++) begin
            logic [36:0] exp_v;
            logic [36:0] got_v;
            exp_v = exp_beat(exp_q[i], i % N, 1'b0, inv);
            got_v = (base + i < beats.size()) ? got_beat(beats[base + i]) : 'x;
            n_checks++;
            if (got_v !== exp_v)
                $display("FAIL %s beat %0d: got %h required %h", name, i, got_v, exp_v);
            else
                n_pass++;
        end
    endtask

    task automatic check_idle_outputs(input string name);
        logic [38:0] got_v;
        got_v = {bus.source_valid, bus.source_sop, bus.source_eop, bus.source_error,
                 bus.source_real, bus.source_imag, inverse};
        n_checks++;
        if (got_v !== '0) $display("FAIL %s outputs: got %h required 0", name, got_v);
        else n_pass++;
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL %s in_ready: got %b required 1", name, bus.in_ready);
        else n_pass++;
`ifdef FFT_FRAMER_ERRCNT_EN
        n_checks++;
        if (err_count !== 16'd0) $display("FAIL %s err_count: got %0d required 0", name, err_count);
        else n_pass++;
`endif
    endtask

    task automatic test_reset();
        reset            = 1'b1;
        enable           = 1'b0;
        inverse_req      = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_data      = '0;
        bus.source_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_idle_outputs("reset");
        n_checks++;
        if (fft_pts !== (LOG2_PTS + 1)'(N)) $display("FAIL fft_pts: got %0d required %0d", fft_pts, N);
        else n_pass++;
    endtask

    task automatic test_single_frame();
        int   base;
        logic inv;
        base        = beats.size();
        inv         = 1'($urandom_range(0, 1));
        inverse_req = inv;
        enable      = 1'b1;
        queue_samples(N, 1'b1);
        run_until(base + N, 200, 0, 1'b0, "single_frame");
        compare_frames(base, N, inv, "single_frame");
        repeat (5) step(0, 1'b0);
        n_checks++;
        if (beats.size() != base + N || bus.source_valid !== 1'b0)
            $display("FAIL single_frame tail: beats %0d valid %b, required %0d and 0",
                     beats.size() - base, bus.source_valid, N);
        else
            n_pass++;
    endtask

    task automatic test_back_to_back();
        int   base;
        logic inv;
        base        = beats.size();
        inv         = 1'($urandom_range(0, 1));
        inverse_req = inv;
        queue_samples(2 * N, 1'b0);
        run_until(base + 2 * N, 300, 0, 1'b0, "back_to_back");
        compare_frames(base, 2 * N, inv, "back_to_back");
        n_checks++;
        if (beats.size() < base + 2 * N ||
            beats[base + N].cyc != beats[base + N - 1].cyc + 1)
            $display("FAIL back_to_back gap: second sop did not follow first eop on the next cycle");
        else
            n_pass++;
    endtask

    task automatic test_stall();
        int   base;
        logic inv;
        base        = beats.size();
        inv         = 1'($urandom_range(0, 1));
        inverse_req = inv;
        stab_viol   = 0;
        chk_stable  = 1'b1;
        queue_samples(N, 1'b0);
        run_until(base + N, 300, 1, 1'b0, "stall");
        chk_stable = 1'b0;
        compare_frames(base, N, inv, "stall");
        n_checks++;
        if (stab_viol != 0) $display("FAIL stall stability: got %0d changes while stalled, required 0", stab_viol);
        else n_pass++;
        bus.source_ready = 1'b1;
    endtask

    task automatic test_abort();
        int   base;
        logic inv;
        base        = beats.size();
        inv         = 1'($urandom_range(0, 1));
        inverse_req = inv;
        queue_samples(3, 1'b0);
        run_until(base + 3, 100, 0, 1'b0, "abort_prefix");
        repeat (3) step(0, 1'b0);
        n_checks++;
        if (beats.size() != base + 3) $display("FAIL abort hold: got %0d beats, required 3", beats.size() - base);
        else n_pass++;
        enable = 1'b0;
        run_until(base + N, 100, 0, 1'b0, "abort_pad");
        for (int i = 0; i < N; i++) begin
            logic [36:0] exp_v;
            logic [36:0] got_v;
            exp_v = (i < 3) ? exp_beat(exp_q[i], i, 1'b1, inv) : exp_beat(16'h0000, i, 1'b1, inv);
            got_v = (base + i < beats.size()) ? got_beat(beats[base + i]) : 'x;
            n_checks++;
            if (got_v !== exp_v) $display("FAIL abort beat %0d: got %h required %h", i, got_v, exp_v);
            else n_pass++;
        end
        repeat (4) step(0, 1'b0);
        n_checks++;
        if (beats.size() != base + N || bus.source_valid !== 1'b0)
            $display("FAIL abort tail: beats %0d valid %b, required %0d and 0",
                     beats.size() - base, bus.source_valid, N);
        else
            n_pass++;
`ifdef FFT_FRAMER_ERRCNT_EN
        n_checks++;
        if (err_count !== 16'd1) $display("FAIL abort err_count: got %0d required 1", err_count);
        else n_pass++;
`endif
        enable = 1'b1;
    endtask

    task automatic test_fifo_full();
        int   base;
        int   acc0;
        logic inv;
        base        = beats.size();
        acc0        = n_acc;
        inv         = 1'($urandom_range(0, 1));
        inverse_req = inv;
        stab_viol   = 0;
        chk_stable  = 1'b1;
        queue_samples(6, 1'b0);
        repeat (10) step(2, 1'b0);
        n_checks++;
        if (bus.in_ready !== 1'b0 || n_acc - acc0 != FIFO_DEPTH || tx_q.size() != 2)
            $display("FAIL fifo_full: in_ready %b accepted %0d pending %0d, required 0 %0d 2",
                     bus.in_ready, n_acc - acc0, tx_q.size(), FIFO_DEPTH);
        else
            n_pass++;
        n_checks++;
        if ({bus.source_valid, bus.source_sop, bus.source_real} !== {1'b1, 1'b1, exp_q[0]} ||
            beats.size() != base)
            $display("FAIL fifo_full head: got %b %b %h, required 1 1 %h",
                     bus.source_valid, bus.source_sop, bus.source_real, exp_q[0]);
        else
            n_pass++;
        for (int i = 0; i < 2; i++) begin
            logic [15:0] s;
            s = 16'($urandom);
            tx_q.push_back(s);
            exp_q.push_back(s);
        end
        run_until(base + N, 200, 0, 1'b0, "fifo_full");
        chk_stable = 1'b0;
        compare_frames(base, N, inv, "fifo_full");
        n_checks++;
        if (stab_viol != 0) $display("FAIL fifo_full stability: got %0d changes while stalled, required 0", stab_viol);
        else n_pass++;
    endtask

    task automatic test_inverse();
        int base;
        base        = beats.size();
        inverse_req = 1'b1;
        queue_samples(N, 1'b0);
        run_until(base + 1, 100, 0, 1'b0, "inverse_sop");
        run_until(base + N, 300, 3, 1'b1, "inverse_a");
        compare_frames(base, N, 1'b1, "inverse_a");
        inverse_req = 1'b0;
        base        = beats.size();
        queue_samples(N, 1'b0);
        run_until(base + N, 300, 0, 1'b0, "inverse_b");
        compare_frames(base, N, 1'b0, "inverse_b");
    endtask

    task automatic test_reset_midframe();
        int base;
        base        = beats.size();
        inverse_req = 1'b1;
        queue_samples(5, 1'b0);
        run_until(base + 2, 100, 0, 1'b0, "midframe_prefix");
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        tx_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_idle_outputs("midframe_reset");
        repeat (20) step(0, 1'b0);
        n_checks++;
        if (beats.size() != base + 2) $display("FAIL midframe discard: got %0d beats, required 2", beats.size() - base);
        else n_pass++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_stall();
        test_abort();
        test_fifo_full();
        test_inverse();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
